gcd_result_display: RTL and testbench

- Downstream consumer of the CPU core's 8-bit GCD result (`GCD_OUTPUT`).
- Converts the binary result to three BCD digits (hundreds/tens/ones) with a sequential shift-add-3 (double-dabble) engine.
- Drives a 3-digit time-multiplexed 7-segment display.
- Sits at board top, between the CPU top and the display pins.

---
 rtl/gcd_result_display.sv | 139 +++++++++++++
 tb/tb_gcd_result_display.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gcd_result_display.sv
// GCD result to 3-digit multiplexed 7-segment display via sequential double-dabble.
// Optional macro GCD_DISPLAY_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module gcd_result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       result_valid,
  input  logic [7:0] result,
  output logic       busy,
  output logic       done,
  output logic       ovr,
  output logic [2:0] an,
  output logic [6:0] seg
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t        state;
  logic [19:0]   work;
  logic [2:0]    count;
  logic [3:0]    hund, tens, ones;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    scan_idx;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    seg_val;

  // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] w);
    logic [19:0] a;
    a = w;
    for (int k = 0; k < 3; k++) begin
      if (a[8+4*k +: 4] >= 4'd5) a[8+4*k +: 4] = a[8+4*k +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      work  <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovr   <= 1'b0;
      hund  <= '0;
      tens  <= '0;
      ones  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (result_valid) begin
            work  <= {12'b0, result};
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (result_valid) ovr <= 1'b1;
          work  <= dd_step(work);
          count <= count + 3'd1;
          if (count == 3'd7) state <= LATCH;
        end
        LATCH: begin
          // A strobe here is still treated as busy and dropped.
          if (result_valid) ovr <= 1'b1;
          hund  <= work[19:16];
          tens  <= work[15:12];
          ones  <= work[11:8];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == LAST) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    digit = ones;
    blank = 1'b0;
    case (scan_idx)
      2'd1:    digit = tens;
      2'd2:    digit = hund;
      default: digit = ones;
    endcase
`ifdef GCD_DISPLAY_LEADING_ZERO_BLANK_EN
    if (scan_idx == 2'd2 && hund == 4'd0) blank = 1'b1;
    if (scan_idx == 2'd1 && hund == 4'd0 && tens == 4'd0) blank = 1'b1;
`endif
    seg_val = blank ? 7'h00 : decode(digit);
  end

  // an and seg registered together so they always switch on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 3'b001;
      seg <= 7'h3F;
    end else begin
      an  <= 3'b001 << scan_idx;
      seg <= seg_val;
    end
  end

endmodule

// File: tb/tb_gcd_result_display.sv
// Scoreboard bench for gcd_result_display: stimulus pushes expected conversions,
// a negedge monitor checks busy/ovr/done timing and the scanned segment pattern.
module tb_gcd_result_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       result_valid = 1'b0;
  logic [7:0] result = 8'd0;
  logic       busy, done, ovr;
  logic [2:0] an;
  logic [6:0] seg;

  gcd_result_display #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .result_valid(result_valid), .result(result),
    .busy(busy), .done(done), .ovr(ovr), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int t;
    int o;
    int done_at;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   acc = 0;
  bit   have_acc = 1'b0;
  int   next_free = 0;
  int   ovr_edge = 32'h7fffffff;
  int   sh_h = 0, sh_t = 0, sh_o = 0;

`ifdef GCD_DISPLAY_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z0 = 7'h00;
`else
  localparam logic [6:0] Z0 = 7'h3F;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int seg_of(input int d);
    case (d)
      0: return 'h3F;  1: return 'h06;  2: return 'h5B;  3: return 'h4F;
      4: return 'h66;  5: return 'h6D;  6: return 'h7D;  7: return 'h07;
      8: return 'h7F;  9: return 'h6F;
      default: return 0;
    endcase
  endfunction

  // Expected segments for the digit currently enabled, from the decimal digits shown.
  function automatic int exp_seg(input logic [2:0] a, input int h, input int t, input int o);
    bit blank_h, blank_t;
    blank_h = 1'b0;
    blank_t = 1'b0;
`ifdef GCD_DISPLAY_LEADING_ZERO_BLANK_EN
    blank_h = (h == 0);
    blank_t = (h == 0) && (t == 0);
`endif
    case (a)
      3'b001:  return seg_of(o);
      3'b010:  return blank_t ? 0 : seg_of(t);
      3'b100:  return blank_h ? 0 : seg_of(h);
      default: return -1;
    endcase
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    bit   be;
    if (rst) begin
      be = have_acc && (cyc >= acc) && (cyc <= acc + 8);
      chk("busy", int'(busy), int'(be));
      chk("ovr", int'(ovr), int'(cyc >= ovr_edge));
      chk("seg", int'(seg), exp_seg(an, sh_h, sh_t, sh_o));
      if (done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_spurious: got done=1 expected no pending conversion at cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.done_at);
          $display("conv %0d%0d%0d done at cycle %0d", e.h, e.t, e.o, cyc);
          sh_h = e.h;
          sh_t = e.t;
          sh_o = e.o;
        end
      end else if (q.size() > 0 && cyc > q[0].done_at) begin
        total++;
        bad++;
        $display("FAIL done_missing: got done=0 expected done at cycle %0d", q[0].done_at);
        void'(q.pop_front());
      end
    end
  end

  task automatic strobe(input int v);
    exp_t x;
    int   e;
    @(negedge clk);
    e = cyc + 1;
    if (e >= next_free) begin
      x.h = v / 100;
      x.t = (v / 10) % 10;
      x.o = v % 10;
      x.done_at = e + 9;
      q.push_back(x);
      acc = e;
      have_acc = 1'b1;
      next_free = e + 10;
    end else if (ovr_edge > e) begin
      ovr_edge = e;
    end
    result = v[7:0];
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  // Waits until the display has settled, then checks one full scan against constants.
  task automatic scan_check(input string name, input logic [6:0] sh, input logic [6:0] st,
                            input logic [6:0] so);
    repeat (14) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      case (an)
        3'b100:  chk({name, "_hund"}, int'(seg), int'(sh));
        3'b010:  chk({name, "_tens"}, int'(seg), int'(st));
        default: chk({name, "_ones"}, int'(seg), int'(so));
      endcase
    end
  endtask

  initial begin
    int c0;
    int d;
    repeat (3) @(negedge clk);
    chk("rst_an", int'(an), 1);
    chk("rst_seg", int'(seg), 'h3F);
    rst = 1'b1;
    c0 = cyc;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovr", int'(ovr), 0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      d = ((cyc - c0 - 1) / 4) % 3;
      chk("scan_an", int'(an), 1 << d);
      chk("scan_seg", int'(seg), (d == 0) ? 'h3F : int'(Z0));
    end

    strobe(150); scan_check("v150", 7'h06, 7'h6D, 7'h3F);
    strobe(255); scan_check("v255", 7'h5B, 7'h6D, 7'h6D);
    strobe(0);   scan_check("v0",   Z0,    Z0,    7'h3F);
    strobe(7);   scan_check("v7",   Z0,    Z0,    7'h07);
    strobe(42);
    repeat (2) @(negedge clk);
    strobe(99);
    scan_check("v42", Z0, 7'h66, 7'h5B);
    chk("ovr_sticky", int'(ovr), 1);

    // Reset in the middle of converting 200, after the fourth shift.
    strobe(200);
    repeat (4) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_an", int'(an), 1);
    chk("midrst_seg", int'(seg), 'h3F);
    chk("midrst_ovr", int'(ovr), 0);
    q.delete();
    have_acc = 1'b0;
    next_free = 0;
    ovr_edge = 32'h7fffffff;
    sh_h = 0; sh_t = 0; sh_o = 0;
    @(negedge clk);
    rst = 1'b1;
    strobe(200); scan_check("v200", 7'h5B, 7'h3F, 7'h3F);

    for (int i = 0; i < 40; i++) begin
      strobe(int'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 18)) @(negedge clk);
    end

    for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
